// File: rtl/instruction_control_pkg.sv
// Shared RV32I opcode constants, ALU operation codes and the decoded control bundle
// used by the instruction decoder and its output register stage.
package instruction_control_pkg;

   localparam logic [6:0] OP_R_TYPE = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD    = 4'b0000;
   localparam logic [3:0] ALU_SUB    = 4'b0001;
   localparam logic [3:0] ALU_AND    = 4'b0010;
   localparam logic [3:0] ALU_OR     = 4'b0011;
   localparam logic [3:0] ALU_XOR    = 4'b0100;
   localparam logic [3:0] ALU_SLL    = 4'b0101;
   localparam logic [3:0] ALU_SRL    = 4'b0110;
   localparam logic [3:0] ALU_SRA    = 4'b0111;
   localparam logic [3:0] ALU_SLT    = 4'b1000;
   localparam logic [3:0] ALU_SLTU   = 4'b1001;
   localparam logic [3:0] ALU_PASS_B = 4'b1010;

   typedef struct packed {
      logic       branch;
      logic       nbranch;
      logic       branch_lt;
      logic       branch_ge;
      logic       branch_ltu;
      logic       branch_geu;
      logic       jal;
      logic       jalr;
      logic       mem_read;
      logic       mem_write;
      logic       io_read;
      logic       io_write;
      logic       memorio_to_reg;
      logic [3:0] alu_op;
      logic       alu_src;
      logic       reg_write;
      logic       sftmd;
   } ctrl_t;

   // alt selects SUB over ADD and SRA over SRL; callers only pass alt=1 where that is legal.
   function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3, input logic alt);
      logic [3:0] op;
      case (funct3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/instruction_control_decode_core.sv
// Purely combinational RV32I control decode; illegal encodings collapse to an all-zero bundle.
module ic_decode_core
   import instruction_control_pkg::*;
#(
   parameter logic [21:0] IO_HIGH = 22'h3FFFFF
) (
   input  logic [31:0] instruction,
   input  logic [21:0] alu_result_high,
   output ctrl_t       ctrl
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       io_space;
   logic       is_shift;
   logic       illegal;
   logic       unused_fields;

   assign opcode        = instruction[6:0];
   assign funct3        = instruction[14:12];
   assign funct7        = instruction[31:25];
   assign io_space      = (alu_result_high == IO_HIGH);
   assign is_shift      = (funct3 == 3'b001) || (funct3 == 3'b101);
   assign unused_fields = ^{instruction[24:15], instruction[11:7]};

   always_comb begin
      ctrl    = '0;
      illegal = 1'b0;
      case (opcode)
         OP_R_TYPE: begin
            // funct7 may only be all-zero, or 0100000 on the add/srl slots (sub/sra).
            illegal = !((funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = alu_from_funct3(funct3, funct7[5]);
            ctrl.sftmd     = is_shift;
         end
         OP_I_ALU: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
            ctrl.sftmd     = is_shift;
         end
         OP_LOAD: begin
            ctrl.alu_src        = 1'b1;
            ctrl.reg_write      = 1'b1;
            ctrl.memorio_to_reg = 1'b1;
            ctrl.alu_op         = ALU_ADD;
            ctrl.io_read        = io_space;
            ctrl.mem_read       = !io_space;
         end
         OP_STORE: begin
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALU_ADD;
            ctrl.io_write  = io_space;
            ctrl.mem_write = !io_space;
         end
         OP_BRANCH: begin
            ctrl.alu_op = ALU_SUB;
            case (funct3)
               3'b000:  ctrl.branch     = 1'b1;
               3'b001:  ctrl.nbranch    = 1'b1;
               3'b100:  ctrl.branch_lt  = 1'b1;
               3'b101:  ctrl.branch_ge  = 1'b1;
               3'b110:  ctrl.branch_ltu = 1'b1;
               3'b111:  ctrl.branch_geu = 1'b1;
               default: illegal         = 1'b1;
            endcase
         end
         OP_JAL: begin
            ctrl.jal       = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_ADD;
         end
         OP_JALR: begin
            ctrl.jalr      = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALU_ADD;
         end
         OP_LUI: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALU_PASS_B;
         end
         OP_AUIPC: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALU_ADD;
         end
         default: illegal = 1'b1;
      endcase
      if (illegal) ctrl = '0;
   end

endmodule

// File: rtl/instruction_control.sv
// RV32I control unit: combinational decode followed by a single register stage,
// so every control output appears one cycle after the instruction is sampled.
module instruction_control
   import instruction_control_pkg::*;
#(
   parameter logic [21:0] IO_HIGH = 22'h3FFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instruction,
   input  logic [21:0] Alu_resultHigh,
   output logic        Branch,
   output logic        nBranch,
   output logic        branch_lt,
   output logic        branch_ge,
   output logic        branch_ltu,
   output logic        branch_geu,
   output logic        jal,
   output logic        jalr,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        IORead,
   output logic        IOWrite,
   output logic        MemorIOToReg,
   output logic [3:0]  ALUop,
   output logic        ALUSrc,
   output logic        RegWrite,
   output logic        sftmd
);

   ctrl_t ctrl_d;
   ctrl_t ctrl_q;

   ic_decode_core #(.IO_HIGH(IO_HIGH)) u_decode (
      .instruction     (instruction),
      .alu_result_high (Alu_resultHigh),
      .ctrl            (ctrl_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ctrl_q <= '0;
      else        ctrl_q <= ctrl_d;
   end

   assign Branch       = ctrl_q.branch;
   assign nBranch      = ctrl_q.nbranch;
   assign branch_lt    = ctrl_q.branch_lt;
   assign branch_ge    = ctrl_q.branch_ge;
   assign branch_ltu   = ctrl_q.branch_ltu;
   assign branch_geu   = ctrl_q.branch_geu;
   assign jal          = ctrl_q.jal;
   assign jalr         = ctrl_q.jalr;
   assign MemRead      = ctrl_q.mem_read;
   assign MemWrite     = ctrl_q.mem_write;
   assign IORead       = ctrl_q.io_read;
   assign IOWrite      = ctrl_q.io_write;
   assign MemorIOToReg = ctrl_q.memorio_to_reg;
   assign ALUop        = ctrl_q.alu_op;
   assign ALUSrc       = ctrl_q.alu_src;
   assign RegWrite     = ctrl_q.reg_write;
   assign sftmd        = ctrl_q.sftmd;

endmodule

// File: tb/tb_instruction_control.sv
// Bench for instruction_control: reference decode model feeds an expected queue,
// registered outputs are popped and compared one cycle after each instruction.
module tb_instruction_control;

   localparam int W = 20;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instruction;
   logic [21:0] Alu_resultHigh;
   logic        Branch, nBranch, branch_lt, branch_ge, branch_ltu, branch_geu;
   logic        jal, jalr, MemRead, MemWrite, IORead, IOWrite, MemorIOToReg;
   logic [3:0]  ALUop;
   logic        ALUSrc, RegWrite, sftmd;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs;
   int           n_checks = 0;
   int           n_fail   = 0;

   instruction_control dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .instruction    (instruction),
      .Alu_resultHigh (Alu_resultHigh),
      .Branch         (Branch),
      .nBranch        (nBranch),
      .branch_lt      (branch_lt),
      .branch_ge      (branch_ge),
      .branch_ltu     (branch_ltu),
      .branch_geu     (branch_geu),
      .jal            (jal),
      .jalr           (jalr),
      .MemRead        (MemRead),
      .MemWrite       (MemWrite),
      .IORead         (IORead),
      .IOWrite        (IOWrite),
      .MemorIOToReg   (MemorIOToReg),
      .ALUop          (ALUop),
      .ALUSrc         (ALUSrc),
      .RegWrite       (RegWrite),
      .sftmd          (sftmd)
   );

   assign obs = {Branch, nBranch, branch_lt, branch_ge, branch_ltu, branch_geu, jal, jalr,
                 MemRead, MemWrite, IORead, IOWrite, MemorIOToReg, ALUop, ALUSrc, RegWrite, sftmd};

   // clock / reset
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
      end
   endtask

   // reference model written directly from the instruction-set rules
   function automatic logic [W-1:0] model(input logic [31:0] ins, input logic [21:0] high);
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [5:0] br;
      logic       j, jr, mr, mw, ir, iw, m2r, src, rw, sft, io;
      logic [3:0] aop;
      logic [3:0] tbl [8];
      op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
      io = (high == 22'h3FFFFF);
      br = '0; j = 0; jr = 0; mr = 0; mw = 0; ir = 0; iw = 0; m2r = 0;
      src = 0; rw = 0; sft = 0; aop = 4'd0;
      tbl[0] = 4'd0; tbl[1] = 4'd5; tbl[2] = 4'd8; tbl[3] = 4'd9;
      tbl[4] = 4'd4; tbl[5] = 4'd6; tbl[6] = 4'd3; tbl[7] = 4'd2;
      if (op == 7'h33) begin
         if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
            rw = 1; aop = tbl[f3] + {3'b0, f7[5]};
            sft = (f3 == 3'd1 || f3 == 3'd5);
         end
      end else if (op == 7'h13) begin
         rw = 1; src = 1; aop = tbl[f3];
         if (f3 == 3'd5 && f7[5]) aop = 4'd7;
         sft = (f3 == 3'd1 || f3 == 3'd5);
      end else if (op == 7'h03) begin
         src = 1; rw = 1; m2r = 1; ir = io; mr = !io;
      end else if (op == 7'h23) begin
         src = 1; iw = io; mw = !io;
      end else if (op == 7'h63) begin
         if (f3 != 3'd2 && f3 != 3'd3) begin
            aop = 4'd1;
            if (f3 == 3'd0)      br = 6'b100000;
            else if (f3 == 3'd1) br = 6'b010000;
            else                 br = 6'b001000 >> (f3 - 3'd4);
         end
      end else if (op == 7'h6F) begin
         j = 1; rw = 1;
      end else if (op == 7'h67) begin
         jr = 1; rw = 1; src = 1;
      end else if (op == 7'h37) begin
         rw = 1; src = 1; aop = 4'd10;
      end else if (op == 7'h17) begin
         rw = 1; src = 1;
      end
      return {br, j, jr, mr, mw, ir, iw, m2r, aop, src, rw, sft};
   endfunction

   // driver: present an instruction, then compare the registered result after the edge
   task automatic apply(input string tag, input logic [31:0] ins, input logic [21:0] high);
      logic [W-1:0] want;
      @(negedge clk);
      instruction    = ins;
      Alu_resultHigh = high;
      exp_q.push_back(model(ins, high));
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      check_eq(tag, obs, want);
      check_eq({tag, "_onehot"}, ($countones(obs[W-1:W-8]) <= 1), 1);
   endtask

   initial begin
      logic [6:0] ops [10];
      logic [31:0] ins;
      logic [21:0] high;
      ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23; ops[4] = 7'h63;
      ops[5] = 7'h6F; ops[6] = 7'h67; ops[7] = 7'h37; ops[8] = 7'h17; ops[9] = 7'h7F;

      rst_n = 1'b0; instruction = 32'h00500093; Alu_resultHigh = '0;
      #1;
      check_eq("reset_outputs", obs, 0);
      @(posedge clk); #1;
      check_eq("reset_held_over_edge", obs, 0);
      @(negedge clk); rst_n = 1'b1;

      apply("addi", 32'h00500093, 22'h0);
      check_eq("addi_regwrite", RegWrite, 1);
      check_eq("addi_alusrc", ALUSrc, 1);
      check_eq("addi_aluop", ALUop, 4'b0000);
      apply("or", 32'h0020E1B3, 22'h0);
      check_eq("or_aluop", ALUop, 4'b0011);
      apply("sra", 32'h4020D1B3, 22'h0);
      check_eq("sra_sftmd", sftmd, 1);
      check_eq("sra_aluop", ALUop, 4'b0111);
      apply("lw_ram", 32'h00402003, 22'h000010);
      check_eq("lw_ram_flags", {MemRead, IORead, MemorIOToReg}, 3'b101);
      apply("lw_io", 32'h00402003, 22'h3FFFFF);
      check_eq("lw_io_flags", {MemRead, IORead}, 2'b01);
      apply("sw_ram", 32'h00112023, 22'h000001);
      check_eq("sw_ram_flags", {MemWrite, IOWrite, RegWrite}, 3'b100);
      apply("sw_io", 32'h00112023, 22'h3FFFFF);
      check_eq("sw_io_flags", {MemWrite, IOWrite}, 2'b01);
      apply("beq", 32'h00208463, 22'h0);
      check_eq("beq_flag", Branch, 1);
      apply("bne", 32'h00209463, 22'h0);
      check_eq("bne_flag", nBranch, 1);
      apply("blt", 32'h0020C463, 22'h0);
      check_eq("blt_flag", branch_lt, 1);
      apply("jal", 32'h0000006F, 22'h0);
      check_eq("jal_flags", {jal, RegWrite}, 2'b11);
      apply("jalr", 32'h00008067, 22'h0);
      check_eq("jalr_flags", {jalr, RegWrite, ALUSrc}, 3'b111);
      apply("lui", 32'h123450B7, 22'h0);
      check_eq("lui_aluop", ALUop, 4'b1010);
      apply("r_bad_funct7", 32'h4020E1B3, 22'h0);
      check_eq("r_bad_funct7_zero", obs, 0);
      apply("branch_f3_010", 32'h0020A463, 22'h0);
      check_eq("branch_f3_010_zero", obs, 0);

      // async reset mid-cycle while outputs are nonzero
      apply("pre_reset", 32'h00500093, 22'h0);
      #2 rst_n = 1'b0;
      #1;
      check_eq("async_reset_clears", obs, 0);
      @(negedge clk); rst_n = 1'b1;
      #1;
      check_eq("no_decode_before_edge", obs, 0);
      apply("post_reset", 32'h00500093, 22'h0);
      apply("opcode_7f", 32'h0000007F, 22'h0);
      check_eq("opcode_7f_zero", obs, 0);

      for (int i = 0; i < 60; i++) begin
         ins = $urandom;
         ins[6:0] = ops[$urandom_range(0, 9)];
         case ($urandom_range(0, 2))
            0: ins[31:25] = 7'h00;
            1: ins[31:25] = 7'h20;
            default: ;
         endcase
         high = ($urandom_range(0, 1) == 1) ? 22'h3FFFFF : 22'($urandom);
         apply("random", ins, high);
      end

      check_eq("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_control.md
INSTRUCTION_CONTROL -- requirements
Module: instruction_control

Interface
REQ-001 Parameter IO_HIGH, default 22'h3FFFFF: value of Alu_resultHigh that selects the memory-mapped IO space.
REQ-002 clk  in  1  single clock; all outputs update on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 instruction  in  32  RV32I instruction word.
REQ-005 Alu_resultHigh  in  22  ALU result bits [31:10], used for RAM/IO selection.
REQ-006 Branch  out  1  beq.
REQ-007 nBranch  out  1  bne.
REQ-008 branch_lt  out  1  blt.
REQ-009 branch_ge  out  1  bge.
REQ-010 branch_ltu  out  1  bltu.
REQ-011 branch_geu  out  1  bgeu.
REQ-012 jal  out  1  jal.
REQ-013 jalr  out  1  jalr.
REQ-014 MemRead  out  1  load from RAM.
REQ-015 MemWrite  out  1  store to RAM.
REQ-016 IORead  out  1  load from IO.
REQ-017 IOWrite  out  1  store to IO.
REQ-018 MemorIOToReg  out  1  writeback source is memory/IO data.
REQ-019 ALUop  out  4  ALU operation code.
REQ-020 ALUSrc  out  1  ALU operand B is the immediate.
REQ-021 RegWrite  out  1  rd is written.
REQ-022 sftmd  out  1  shift instruction.

Function
REQ-023 All outputs SHALL be registered: decode of instruction and Alu_resultHigh sampled at rising clk edge N appears after edge N (one-cycle latency), held until the next edge.
REQ-024 ALUop encoding SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU, 1010 PASS_B.
REQ-025 R-type (0110011): RegWrite=1, ALUSrc=0; ALUop from funct3 plus funct7[5] (funct7[5]=1 only with add->SUB, srl->SRA); any other funct7 is illegal.
REQ-026 I-ALU (0010011): RegWrite=1, ALUSrc=1; ALUop from funct3; funct3=101 uses funct7[5] for SRA/SRL.
REQ-027 sftmd=1 exactly for sll, srl, sra, slli, srli, srai.
REQ-028 Load (0000011): ALUSrc=1, RegWrite=1, MemorIOToReg=1, ALUop=ADD; IORead=1,MemRead=0 when Alu_resultHigh==IO_HIGH, else MemRead=1,IORead=0.
REQ-029 Store (0100011): ALUSrc=1, ALUop=ADD, RegWrite=0; IOWrite=1,MemWrite=0 when Alu_resultHigh==IO_HIGH, else MemWrite=1,IOWrite=0.
REQ-030 Branch (1100011): ALUop=SUB, ALUSrc=0, RegWrite=0; funct3 000/001/100/101/110/111 asserts Branch/nBranch/branch_lt/branch_ge/branch_ltu/branch_geu respectively; 010/011 illegal.
REQ-031 jal (1101111): jal=1, RegWrite=1, ALUSrc=0, ALUop=ADD.
REQ-032 jalr (1100111): jalr=1, RegWrite=1, ALUSrc=1, ALUop=ADD.
REQ-033 lui (0110111): RegWrite=1, ALUSrc=1, ALUop=PASS_B; auipc (0010111): RegWrite=1, ALUSrc=1, ALUop=ADD.
REQ-034 Every output not named for an instruction SHALL be 0; unknown opcode or illegal funct SHALL drive all outputs 0.
REQ-035 At most one of the six branch flags, jal, jalr SHALL be 1 in any cycle.

Reset
REQ-036 rst_n low SHALL immediately force every output to 0 (ALUop=0000), independent of clk; first decode appears at the first rising edge after release.

Structure
REQ-037 Opcode constants and ALUop encodings SHALL live in a shared package.
REQ-038 Combinational decode SHALL be one sub-module, ic_decode_core; the top adds the output register stage.

Verification
REQ-039 addi x1,x0,5 (0x00500093), edge -> RegWrite=1, ALUSrc=1, ALUop=0000.
REQ-040 or x3,x1,x2 (0x0020E1B3) -> RegWrite=1, ALUop=0011; sra x3,x1,x2 (0x4020D1B3) -> sftmd=1, ALUop=0111.
REQ-041 lw 0x00402003 with Alu_resultHigh=22'h000010 -> MemRead=1, IORead=0, MemorIOToReg=1; then 22'h3FFFFF -> IORead=1, MemRead=0.
REQ-042 sw 0x00112023 with 22'h000001 -> MemWrite=1; with 22'h3FFFFF -> IOWrite=1, MemWrite=0.
REQ-043 beq/bne/blt (funct3 000/001/100), jal 0x0000006F, jalr 0x00008067 -> matching flag 1; jal/jalr also RegWrite=1, jalr ALUSrc=1.
REQ-044 Assert rst_n=0 mid-stream while outputs nonzero -> all outputs 0 before next clk edge; opcode 0x7F -> all 0.
